alu_seq: RTL
============

# alu_seq

Sequential, parametrised successor to the CPU's combinational ALU. It registers its result and flags, and accepts one operation per Start/Done handshake. It adds the N (negative) and V (overflow) flags, carry-chained ADC/SBC, an iterative shift-add multiply, and iterative multi-bit shifts. It sits in the execute stage, and the control unit holds its next issue until Done.

## Interface
Parameters:
- WIDTH_DATA_LENGTH, 8: operand and result width W (W ≥ 2).
- WIDTH_ALUSEL_LENGTH, 4: opcode width; the encoding is fixed at 4 bits.

Ports:
- Clk  in  1  the single clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- DataA  in  W  operand A; latched on an accepted Start.
- DataB  in  W  operand B; latched on an accepted Start. For shift ops, the amount is DataB[$clog2(W)-1:0].
- ALUSel  in  4  opcode; latched on an accepted Start.
- WriteCZ  in  1  flag-update enable; latched on an accepted Start.
- Busy  out  1  high while an iterative op runs.
- Done  out  1  one-cycle pulse; DataOut and the flags are valid from this cycle.
- DataOut  out  W  registered result; holds until the next Done.
- CF, ZF, NF, VF  out  1 each  registered carry/borrow, zero, negative and signed-overflow flags.

## Operation
Opcodes (single-cycle unless marked iterative):
- 0000 A; 0001 B; 0010 A+1; 0011 B+1; 0100 A+B; 0101 A−B.
- 0110 A&B; 0111 A|B; 1000 A>>1; 1001 A<<1.
- 1010 ADC: A+B+CF.
- 1011 SBC: A−B−CF.
- 1100 MUL (iterative): shift-add over W steps. DataOut is the low W bits of the 2W-bit product.
- 1101 SHL by amount n (iterative): one bit per cycle.
- 1110 SHR by amount n (iterative): logical, one bit per cycle.
- 1111: reserved. Gives DataOut=0, CF=0 and VF=0, with ZF and NF following DataOut.

Arithmetic is done in W+1 bits, and the carry is bit W:
- Add ops: CF = carry out.
- SUB/SBC: CF = borrow, i.e. 1 when the unsigned result is below zero.
- A>>1: CF=0. A<<1: CF=A[W-1].
- SHL/SHR by n: CF = the last bit shifted out; n=0 gives CF=0.
- MUL: CF=1 if the high half of the product is nonzero.
- Logical ops and pass-throughs: CF=0.

Other flags:
- ZF = (DataOut==0). NF = DataOut[W-1].
- VF = signed overflow for 0100/1010 (operands' signs equal, result sign differs) and for 0101/1011 (operands' signs differ, result sign differs from A). VF=0 for all other ops.
- ADC/SBC use the CF register value at the Start-accept cycle.

Flag update:
- On Done, all four flags update only if the latched WriteCZ=1. Otherwise they hold.
- DataOut always updates on Done.

FSM:
- IDLE: Start=1 latches the operands, opcode and WriteCZ.
  - Single-cycle op, or shift with n=0: register the result, pulse Done next cycle, stay in IDLE.
  - Otherwise: load counter = W (MUL) or n (shifts) and go to RUN.
- RUN: Busy=1. Do one step per cycle and decrement the counter. When the counter reaches 1, the next edge writes DataOut and flags, pulses Done and returns to IDLE.

## Timing
- Start accepted at edge T:
  - Single-cycle ops: Done=1 in cycle T+1 and Busy never rises.
  - Iterative ops with N steps: Busy=1 for cycles T+1..T+N, then Done=1 with Busy=0 in cycle T+N+1.
  - MUL takes N=W steps (8-bit: Done in cycle T+9). Shifts take N=n steps.
- Start while Busy=1 is ignored. Input changes during RUN have no effect.
- Start in the same cycle as Done is accepted (back-to-back issue).
- Reset: in the cycle after Rst=1, DataOut=0, CF=ZF=NF=VF=0, Busy=0, Done=0 and the FSM is in IDLE.
  - An in-flight op is discarded and produces no Done.
  - Rst has priority over Start in the same cycle.

## Test plan
- Reset, then ADD 0xFF+0x01 with WriteCZ=1 → Done at T+1, DataOut=0x00, CF=1, ZF=1, NF=0, VF=0. Then ADC 0x10+0x00 → 0x11.
- ADD 0x7F+0x01 → 0x80, VF=1, NF=1, CF=0. SUB 0x03−0x05 → 0xFE, CF=1, NF=1, VF=0.
- MUL 0x0F×0x11 → Busy for 8 cycles, Done at T+9, DataOut=0xFF, CF=0. MUL 0x20×0x10 → DataOut=0x00, CF=1, ZF=1.
- SHL 0x81 by 3 → Busy for 3 cycles, DataOut=0x08, CF=0. SHR 0x81 by 1 → 0x40, CF=1. SHL by 0 → Done at T+1, DataOut=A, CF=0.
- WriteCZ=0 on SUB 0x00−0x01 after a cycle with CF=ZF=1 → DataOut=0xFF, flags unchanged. Start pulsed during a running MUL → ignored, with exactly one Done.
- Rst asserted mid-MUL → next cycle all outputs 0, no Done. A fresh Start is then accepted normally.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: one operation per Start/Done handshake, registered result and C/Z/N/V flags.
// Latency: single-cycle ops and zero-length shifts give Done one cycle after Start; MUL takes W+1, SHL/SHR by n take n+1.
// Backpressure: Start is ignored while Busy is high; a Start in the Done cycle is accepted.
module alu_seq #(
    parameter int WIDTH_DATA_LENGTH   = 8,
    parameter int WIDTH_ALUSEL_LENGTH = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic [WIDTH_DATA_LENGTH-1:0]   DataA,
    input  logic [WIDTH_DATA_LENGTH-1:0]   DataB,
    input  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
    input  logic                           WriteCZ,
    output logic                           Busy,
    output logic                           Done,
    output logic [WIDTH_DATA_LENGTH-1:0]   DataOut,
    output logic                           CF,
    output logic                           ZF,
    output logic                           NF,
    output logic                           VF
);
    localparam int W  = WIDTH_DATA_LENGTH;
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W) + 1;

    localparam logic [WIDTH_ALUSEL_LENGTH-1:0] OP_MUL = 4'b1100;
    localparam logic [WIDTH_ALUSEL_LENGTH-1:0] OP_SHL = 4'b1101;
    localparam logic [WIDTH_ALUSEL_LENGTH-1:0] OP_SHR = 4'b1110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state, state_nxt;
    logic [WIDTH_ALUSEL_LENGTH-1:0] op_q;
    logic                           wcz_q;
    logic [W-1:0]                   a_q;
    logic [2*W-1:0]                 p, p_nxt;    // MUL: {partial high, multiplier}; shifts: low half is the operand
    logic [CW-1:0]                  cnt;
    logic [W:0]                     mul_sum;
    logic                           step_cf;
    logic [W-1:0]                   it_res;
    logic                           it_cf;

    logic [W:0]                     ext_a, ext_b, wide;
    logic [W-1:0]                   sc_res;
    logic                           sc_cf, sc_vf;

    logic [SW-1:0]                  amt;
    logic                           is_shift, accept, iter_req;

    assign amt      = DataB[SW-1:0];
    assign is_shift = (ALUSel == OP_SHL) || (ALUSel == OP_SHR);
    assign accept   = Start && (state == IDLE);
    assign iter_req = accept && ((ALUSel == OP_MUL) || (is_shift && (amt != '0)));

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and Busy: leave RUN on the edge that completes the last step.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        case (state)
            IDLE: if (iter_req) state_nxt = RUN;
            RUN: begin
                Busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result straight from the live inputs; arithmetic in W+1 bits, carry/borrow at bit W.
    always_comb begin
        ext_a  = {1'b0, DataA};
        ext_b  = {1'b0, DataB};
        wide   = '0;
        sc_res = '0;
        sc_cf  = 1'b0;
        sc_vf  = 1'b0;
        case (ALUSel)
            4'b0000: sc_res = DataA;
            4'b0001: sc_res = DataB;
            4'b0010: begin wide = ext_a + (W+1)'(1); sc_res = wide[W-1:0]; sc_cf = wide[W]; end
            4'b0011: begin wide = ext_b + (W+1)'(1); sc_res = wide[W-1:0]; sc_cf = wide[W]; end
            4'b0100, 4'b1010: begin
                wide   = ext_a + ext_b + ((ALUSel == 4'b1010) ? {{W{1'b0}}, CF} : '0);
                sc_res = wide[W-1:0];
                sc_cf  = wide[W];
                sc_vf  = (DataA[W-1] == DataB[W-1]) && (wide[W-1] != DataA[W-1]);
            end
            4'b0101, 4'b1011: begin
                wide   = ext_a - ext_b - ((ALUSel == 4'b1011) ? {{W{1'b0}}, CF} : '0);
                sc_res = wide[W-1:0];
                sc_cf  = wide[W];
                sc_vf  = (DataA[W-1] != DataB[W-1]) && (wide[W-1] != DataA[W-1]);
            end
            4'b0110: sc_res = DataA & DataB;
            4'b0111: sc_res = DataA | DataB;
            4'b1000: sc_res = DataA >> 1;
            4'b1001: begin sc_res = DataA << 1; sc_cf = DataA[W-1]; end
            4'b1101, 4'b1110: sc_res = DataA;   // only reached with a zero shift amount
            default: ;                          // reserved: zero result, no carry/overflow
        endcase
    end

    // One iterative step; the final step's outcome is written directly into DataOut.
    always_comb begin
        p_nxt   = p;
        step_cf = 1'b0;
        mul_sum = '0;
        case (op_q)
            OP_MUL: begin
                mul_sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a_q} : '0);
                p_nxt   = {mul_sum, p[W-1:1]};
            end
            OP_SHL: begin p_nxt[W-1:0] = {p[W-2:0], 1'b0}; step_cf = p[W-1]; end
            OP_SHR: begin p_nxt[W-1:0] = {1'b0, p[W-1:1]}; step_cf = p[0];   end
            default: ;
        endcase
        it_res = p_nxt[W-1:0];
        it_cf  = (op_q == OP_MUL) ? |p_nxt[2*W-1:W] : step_cf;
    end

    // Operand capture, iteration, and result/flag registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q    <= '0;
            wcz_q   <= 1'b0;
            a_q     <= '0;
            p       <= '0;
            cnt     <= '0;
            Done    <= 1'b0;
            DataOut <= '0;
            CF      <= 1'b0;
            ZF      <= 1'b0;
            NF      <= 1'b0;
            VF      <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                op_q  <= ALUSel;
                wcz_q <= WriteCZ;
                a_q   <= DataA;
                if (iter_req) begin
                    p   <= (ALUSel == OP_MUL) ? {{W{1'b0}}, DataB} : {{W{1'b0}}, DataA};
                    cnt <= (ALUSel == OP_MUL) ? CW'(W) : {1'b0, amt};
                end else begin
                    DataOut <= sc_res;
                    Done    <= 1'b1;
                    if (WriteCZ) begin
                        CF <= sc_cf;
                        ZF <= (sc_res == '0);
                        NF <= sc_res[W-1];
                        VF <= sc_vf;
                    end
                end
            end else if (state == RUN) begin
                p   <= p_nxt;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    DataOut <= it_res;
                    Done    <= 1'b1;
                    if (wcz_q) begin
                        CF <= it_cf;
                        ZF <= (it_res == '0);
                        NF <= it_res[W-1];
                        VF <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
